// File: rtl/cfu_requant_pkg.sv
// Shared constants and stage payload type for the cfu_requant int32-to-int8 requantizer.
package cfu_requant_pkg;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  // Rounding nudges applied to the 64-bit product before the divide by 2^31.
  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

  typedef struct packed {
    logic signed [31:0] data;
    logic signed [31:0] mult;
    logic [4:0]         rs;
    logic               sat;
  } stage_t;

endpackage

// File: rtl/cfu_srdhm.sv
// Saturating rounding doubling high multiply: combinational S2 of cfu_requant.
module cfu_srdhm
  import cfu_requant_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] h,
  output logic               sat
);

  logic signed [63:0] p;
  logic signed [63:0] pn;
  logic signed [63:0] pt;

  always_comb begin
    p   = 64'(a) * 64'(b);
    pn  = p + ((p >= 0) ? NUDGE_POS : NUDGE_NEG);
    // Bias negative values up so the arithmetic shift truncates toward zero.
    pt  = (pn < 0) ? (pn + 64'sd2147483647) : pn;
    sat = (a == INT32_MIN) && (b == INT32_MIN);
    h   = sat ? INT32_MAX : 32'(pt >>> 31);
  end

endmodule

// File: rtl/cfu_requant.sv
// Three-stage int32-to-int8 requantizer (bias, shift, SRDHM, rounding shift, offset, clamp).
// Optional saturation counter built only when CFU_REQUANT_SATCNT_EN is defined.
module cfu_requant
  import cfu_requant_pkg::*;
#(
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_acc,
  input  logic [31:0]        in_bias,
  input  logic [31:0]        in_mult,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [31:0]        cfg_out_offset,
  input  logic [7:0]         cfg_act_min,
  input  logic [7:0]         cfg_act_max,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [15:0]        sat_count
);

  localparam logic signed [SHIFT_W:0] RS_MAX = 31;

  logic v1, v2, v3;
  logic en1, en2, en3;
  stage_t s1, s2, s1_d, s2_d;
  logic sat3, sat3_d, clamp;
  logic [7:0] out_d;

  logic signed [SHIFT_W:0] sh_ext, neg_sh, ls;
  logic [31:0] x;

  logic signed [31:0] h2;
  logic               sat2;
  logic [31:0] mask, rem, thr, q, y, amin, amax;
  logic unused_mult;

  // Valid/ready: a transfer happens on a rising edge where valid && ready; a
  // stage loads when it is empty or its content moves on in the same edge.
  always_comb begin
    en3      = !v3 || out_ready;
    en2      = !v2 || en3;
    en1      = !v1 || en2;
    in_ready = en1;
  end

  assign out_valid = v3;

  // S1: bias add, left shift, right-shift amount.
  always_comb begin
    sh_ext = {in_shift[SHIFT_W-1], in_shift};
    neg_sh = -sh_ext;
    ls     = sh_ext[SHIFT_W] ? '0 : sh_ext;
    x      = in_acc + in_bias;
    s1_d.data = x << ls;
    s1_d.mult = in_mult;
    s1_d.sat  = 1'b0;
    if (neg_sh[SHIFT_W] || (neg_sh == '0)) s1_d.rs = '0;
    else if (neg_sh >= RS_MAX)             s1_d.rs = 5'd31;
    else                                   s1_d.rs = neg_sh[4:0];
  end

  cfu_srdhm u_srdhm (
    .a   (s1.data),
    .b   (s1.mult),
    .h   (h2),
    .sat (sat2)
  );

  always_comb begin
    s2_d.data = h2;
    s2_d.mult = '0;
    s2_d.rs   = s1.rs;
    s2_d.sat  = sat2 || s1.sat;
  end

  assign unused_mult = ^s2.mult;

  // S3: round-half-away rounding shift, output offset, activation clamp.
  always_comb begin
    mask  = (32'd1 << s2.rs) - 32'd1;
    rem   = s2.data & mask;
    thr   = (mask >> 1) + {31'd0, s2.data[31]};
    q     = 32'(s2.data >>> s2.rs) + {31'd0, (rem > thr)};
    y     = q + cfg_out_offset;
    amin  = {{24{cfg_act_min[7]}}, cfg_act_min};
    amax  = {{24{cfg_act_max[7]}}, cfg_act_max};
    clamp = 1'b0;
    out_d = y[7:0];
    if ($signed(y) < $signed(amin)) begin
      out_d = cfg_act_min;
      clamp = 1'b1;
    end else if ($signed(y) > $signed(amax)) begin
      out_d = cfg_act_max;
      clamp = 1'b1;
    end
    sat3_d = s2.sat || clamp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1       <= '0;
      s2       <= '0;
      out_data <= '0;
      sat3     <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en1 && in_valid) s1 <= s1_d;
      if (en2 && v1)       s2 <= s2_d;
      if (en3 && v2) begin
        out_data <= out_d;
        sat3     <= sat3_d;
      end
    end
  end

`ifdef CFU_REQUANT_SATCNT_EN
  logic [15:0] sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= '0;
    end else if (v3 && out_ready && sat3 && (sat_q != 16'hFFFF)) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  assign sat_count = sat_q;
`else
  logic unused_sat;

  assign unused_sat = sat3;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_cfu_requant.sv
// Directed self-checking bench for cfu_requant (value, rounding, saturation, flow control, reset).
module tb_cfu_requant;

  localparam int SHIFT_W = 6;
`ifdef CFU_REQUANT_SATCNT_EN
  localparam int SAT_EXP = 2;
`else
  localparam int SAT_EXP = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_acc, in_bias, in_mult;
  logic [SHIFT_W-1:0] in_shift;
  logic [31:0]        cfg_out_offset;
  logic [7:0]         cfg_act_min, cfg_act_max;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic [15:0]        sat_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cfu_requant #(.SHIFT_W(SHIFT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_acc         (in_acc),
    .in_bias        (in_bias),
    .in_mult        (in_mult),
    .in_shift       (in_shift),
    .cfg_out_offset (cfg_out_offset),
    .cfg_act_min    (cfg_act_min),
    .cfg_act_max    (cfg_act_max),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .sat_count      (sat_count)
  );

  // Driver: one transaction into an empty pipe, then wait (bounded) for its result.
  task automatic send_one(input int acc, input int bias, input int mult, input int sh,
                          output logic [7:0] res, output bit timed_out);
    @(negedge clk);
    in_valid  = 1'b1;
    in_acc    = acc;
    in_bias   = bias;
    in_mult   = mult;
    in_shift  = SHIFT_W'(sh);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    timed_out = 1'b1;
    res       = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        res       = out_data;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input int offset, input int amin, input int amax);
    cfg_out_offset = offset;
    cfg_act_min    = 8'(amin);
    cfg_act_max    = 8'(amax);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_data !== 8'd0) begin failures++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
    checks++;
    if (sat_count !== 16'd0) begin failures++; $display("FAIL rst_sat_count got=%0d exp=0", sat_count); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_latency();
    set_cfg(0, -128, 127);
    @(negedge clk);
    in_valid  = 1'b1;
    in_acc    = 100;
    in_bias   = 0;
    in_mult   = 32'h4000_0000;
    in_shift  = '0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      checks++;
      if (out_valid !== (e == 3)) begin
        failures++;
        $display("FAIL lat_out_valid_edge%0d got=%b exp=%b", e, out_valid, (e == 3));
      end
      if (e < 3) @(negedge clk);
    end
    checks++;
    if (out_data !== 8'd50) begin failures++; $display("FAIL lat_value got=%0d exp=50", $signed(out_data)); end
  endtask

  task automatic test_srdhm_rounding();
    int         acc_t[3]  = '{3, -3, -10};
    int         bias_t[3] = '{0, 0, 13};
    logic [7:0] exp_t[3]  = '{8'd2, 8'hFF, 8'd2};
    logic [7:0] r;
    bit         to;
    set_cfg(0, -128, 127);
    for (int i = 0; i < 3; i++) begin
      send_one(acc_t[i], bias_t[i], 32'h4000_0000, 0, r, to);
      checks++;
      if (to || r !== exp_t[i]) begin
        failures++;
        $display("FAIL srdhm_%0d got=%0d exp=%0d timeout=%0d", i, $signed(r), $signed(exp_t[i]), to);
      end
    end
  endtask

  task automatic test_right_shift();
    int         acc_t[3]  = '{12, -12, 5};
    int         mult_t[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h4000_0000};
    int         sh_t[3]   = '{-3, -3, 2};
    int         off_t[3]  = '{5, 5, 0};
    logic [7:0] exp_t[3]  = '{8'd7, 8'd3, 8'd10};
    logic [7:0] r;
    bit         to;
    for (int i = 0; i < 3; i++) begin
      set_cfg(off_t[i], -128, 127);
      send_one(acc_t[i], 0, mult_t[i], sh_t[i], r, to);
      checks++;
      if (to || r !== exp_t[i]) begin
        failures++;
        $display("FAIL shift_%0d got=%0d exp=%0d timeout=%0d", i, $signed(r), $signed(exp_t[i]), to);
      end
    end
    set_cfg(0, -128, 127);
  endtask

  task automatic test_saturation();
    logic [7:0] r;
    bit         to;
    set_cfg(0, -128, 127);
    send_one(32'h8000_0000, 0, 32'h8000_0000, 0, r, to);
    checks++;
    if (to || r !== 8'd127) begin failures++; $display("FAIL sat_overflow got=%0d exp=127 timeout=%0d", $signed(r), to); end
    @(negedge clk);
    set_cfg(0, -20, 20);
    send_one(1000, 0, 32'h7FFF_FFFF, 0, r, to);
    checks++;
    if (to || r !== 8'd20) begin failures++; $display("FAIL sat_clamp got=%0d exp=20 timeout=%0d", $signed(r), to); end
    @(negedge clk);
    checks++;
    if (sat_count !== 16'(SAT_EXP)) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=%0d", sat_count, SAT_EXP);
    end
    set_cfg(0, -128, 127);
  endtask

  task automatic test_backpressure();
    int         acc_t[6] = '{10, 20, -30, 40, 51, -60};
    logic [7:0] exp_q[$];
    logic [7:0] held = '0;
    logic [7:0] exp;
    bit         was_stalled = 1'b0;
    int         idx = 0, held_cnt = 0, got = 0;
    exp_q = '{8'd5, 8'd10, 8'hF1, 8'd20, 8'd26, 8'hE2};
    set_cfg(0, -128, 127);
    for (int k = 0; k < 40 && got < 6; k++) begin
      @(negedge clk);
      out_ready = !(k >= 2 && k <= 7);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        in_acc   = acc_t[idx];
        in_bias  = 0;
        in_mult  = 32'h4000_0000;
        in_shift = '0;
      end
      #1;
      checks++;
      if (in_ready !== !(held_cnt == 3 && !out_ready)) begin
        failures++;
        $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", k, in_ready, !(held_cnt == 3 && !out_ready));
      end
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++;
          $display("FAIL bp_hold cycle=%0d got=%b/%0d exp=1/%0d", k, out_valid, out_data, held);
        end
      end
      was_stalled = out_valid && !out_ready;
      held        = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra got=%0d exp=none", $signed(out_data));
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            failures++;
            $display("FAIL bp_data_%0d got=%0d exp=%0d", got, $signed(out_data), $signed(exp));
          end
        end
        got++;
        held_cnt--;
      end
      if (in_valid && in_ready) begin
        idx++;
        held_cnt++;
      end
    end
    checks++;
    if (got != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    bit         to;
    set_cfg(0, -128, 127);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_acc    = 100;
    in_bias   = 0;
    in_mult   = 32'h4000_0000;
    in_shift  = '0;
    @(negedge clk);
    in_acc    = 20;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (sat_count !== 16'd0) begin failures++; $display("FAIL rmid_sat_count got=%0d exp=0", sat_count); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_data !== 8'd0) begin failures++; $display("FAIL rmid_out_data got=%0d exp=0", out_data); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_ghost_%0d got=%b exp=0", i, out_valid); end
    end
    send_one(-3, 0, 32'h4000_0000, 0, r, to);
    checks++;
    if (to || r !== 8'hFF) begin failures++; $display("FAIL rmid_after got=%0d exp=-1 timeout=%0d", $signed(r), to); end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_bias   = '0;
    in_mult   = '0;
    in_shift  = '0;
    out_ready = 1'b1;
    set_cfg(0, -128, 127);
    test_reset();
    test_basic_latency();
    test_srdhm_rounding();
    test_right_shift();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
